// File: rtl/fetch_thread_sched.sv
// Multithreaded fetch front-end: per-thread PCs and fetch FSMs, stall-aware
// round-robin issue to the I-TLB/I-cache, and same-cycle lookup result handling.
module fetch_thread_sched #(
    parameter int                 N_THREADS  = 4,
    parameter int                 VADDR_W    = 32,
    parameter int                 WORD_BYTES = 4,
    parameter logic [VADDR_W-1:0] RESET_PC   = VADDR_W'(32'h0000_1000),
    localparam int                TID_W      = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_id_ready,
    input  logic [N_THREADS-1:0] i_ext_stall,
    output logic                 o_issue_valid,
    output logic [TID_W-1:0]     o_issue_thread,
    output logic [VADDR_W-1:0]   o_issue_pc,
    input  logic                 i_lookup_hit,
    input  logic                 i_lookup_itlb_miss,
    input  logic                 i_lookup_icache_miss,
    input  logic                 i_fill_valid,
    input  logic [TID_W-1:0]     i_fill_thread,
    input  logic                 i_redirect_en,
    input  logic [TID_W-1:0]     i_redirect_thread,
    input  logic [VADDR_W-1:0]   i_redirect_pc,
    output logic [N_THREADS-1:0] o_thread_waiting
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        INFLIGHT  = 2'd1,
        WAIT_FILL = 2'd2,
        WAIT_TLB  = 2'd3
    } thr_state_t;

    thr_state_t           r_state     [N_THREADS];
    thr_state_t           w_state_nxt [N_THREADS];
    logic [VADDR_W-1:0]   r_pc        [N_THREADS];
    logic [VADDR_W-1:0]   w_pc_nxt    [N_THREADS];
    logic [TID_W-1:0]     r_ptr;
    logic                 r_issue_valid;
    logic [TID_W-1:0]     r_issue_thread;
    logic [VADDR_W-1:0]   r_issue_pc;
    logic [N_THREADS-1:0] r_waiting;

    logic [N_THREADS-1:0] w_eligible;
    logic [N_THREADS-1:0] w_waiting_nxt;
    logic [TID_W-1:0]     w_winner;
    logic                 w_found;
    logic                 w_issue;

    // A thread being redirected this cycle is held back so its stale PC is never issued.
    always_comb begin
        w_eligible = '0;
        for (int t = 0; t < N_THREADS; t++) begin
            w_eligible[t] = (r_state[t] == RUN) && !i_ext_stall[t] &&
                            !(i_redirect_en && (i_redirect_thread == TID_W'(t)));
        end
    end

    // Descending scan so the nearest thread after the pointer is the last (winning) assignment.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = N_THREADS; k >= 1; k--) begin
            automatic int idx = (int'(r_ptr) + k) % N_THREADS;
            if (w_eligible[idx]) begin
                w_found  = 1'b1;
                w_winner = TID_W'(idx);
            end
        end
    end

    assign w_issue = i_id_ready && w_found;

    // Later assignments override earlier ones: lookup, then fill, then issue, then redirect.
    always_comb begin
        w_waiting_nxt = '0;
        for (int t = 0; t < N_THREADS; t++) begin
            w_state_nxt[t] = r_state[t];
            w_pc_nxt[t]    = r_pc[t];
            if (r_issue_valid && (r_issue_thread == TID_W'(t)) && (r_state[t] == INFLIGHT)) begin
                if (i_lookup_itlb_miss) begin
                    w_state_nxt[t] = WAIT_TLB;
                end else if (i_lookup_icache_miss) begin
                    w_state_nxt[t] = WAIT_FILL;
                end else if (i_lookup_hit) begin
                    w_state_nxt[t] = RUN;
                    w_pc_nxt[t]    = r_pc[t] + VADDR_W'(WORD_BYTES);
                end else begin
                    w_state_nxt[t] = WAIT_FILL;
                end
            end
            if (i_fill_valid && (i_fill_thread == TID_W'(t)) && (r_state[t] == WAIT_FILL)) begin
                w_state_nxt[t] = RUN;
            end
            if (w_issue && (w_winner == TID_W'(t))) begin
                w_state_nxt[t] = INFLIGHT;
            end
            if (i_redirect_en && (i_redirect_thread == TID_W'(t))) begin
                w_state_nxt[t] = RUN;
                w_pc_nxt[t]    = i_redirect_pc;
            end
            w_waiting_nxt[t] = (w_state_nxt[t] == WAIT_FILL) || (w_state_nxt[t] == WAIT_TLB);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < N_THREADS; t++) begin
                r_state[t] <= RUN;
                r_pc[t]    <= RESET_PC;
            end
            r_ptr          <= TID_W'(N_THREADS - 1);
            r_issue_valid  <= 1'b0;
            r_issue_thread <= '0;
            r_issue_pc     <= '0;
            r_waiting      <= '0;
        end else begin
            for (int t = 0; t < N_THREADS; t++) begin
                r_state[t] <= w_state_nxt[t];
                r_pc[t]    <= w_pc_nxt[t];
            end
            r_issue_valid <= w_issue;
            if (w_issue) begin
                r_issue_thread <= w_winner;
                r_issue_pc     <= r_pc[w_winner];
                r_ptr          <= w_winner;
            end
            r_waiting <= w_waiting_nxt;
        end
    end

    assign o_issue_valid    = r_issue_valid;
    assign o_issue_thread   = r_issue_thread;
    assign o_issue_pc       = r_issue_pc;
    assign o_thread_waiting = r_waiting;

endmodule

// File: doc/fetch_thread_sched.md
Name: fetch_thread_sched

Overview:
- Parametrised multithreaded fetch front-end. Owns per-thread PCs and fetch-state FSMs.
- Picks one eligible thread per cycle by stall-aware round-robin and issues its PC to the I-TLB/I-cache lookup.
- Consumes the same-cycle lookup result to advance, park or wake each thread. Handles per-thread redirects from branch resolution and the exception handler.
- Sits at the head of the IF stage, feeding the itlb/icache pair; the lookup output drives the IF/ID register.

Parameters:
- N_THREADS, 4, number of hardware threads (>=1).
- VADDR_W, 32, virtual address width.
- WORD_BYTES, 4, PC increment on a successful fetch.
- RESET_PC, 32'h0000_1000, PC of every thread after reset.
- Derived: TID_W = max(1, clog2(N_THREADS)).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_ready  in  1  downstream can accept a fetch this cycle.
- ext_stall  in  N_THREADS  per-thread backend stall; a stalled thread is not selected.
- issue_valid  out  1  registered; fetch issued this cycle.
- issue_thread  out  TID_W  registered; thread of the issued fetch.
- issue_pc  out  VADDR_W  registered; PC of the issued fetch.
- lookup_hit  in  1  same-cycle result for the issued fetch: instruction delivered.
- lookup_itlb_miss  in  1  same-cycle result: translation miss.
- lookup_icache_miss  in  1  same-cycle result: cache miss, refill started.
- fill_valid  in  1  memory refill for a thread completed.
- fill_thread  in  TID_W  thread whose refill completed.
- redirect_en  in  1  PC redirect (branch or exception).
- redirect_thread  in  TID_W  thread to redirect.
- redirect_pc  in  VADDR_W  new PC.
- thread_waiting  out  N_THREADS  registered; bit t is high when thread t is in WAIT_FILL or WAIT_TLB.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state:
  - All threads are in RUN with pc = RESET_PC.
  - issue_valid = 0, issue_thread = 0, issue_pc = 0, thread_waiting = 0.
  - Round-robin pointer = N_THREADS-1, so thread 0 is served first.
  - Reset overrides every other input in that cycle.
- Per-thread FSM states: RUN, INFLIGHT, WAIT_FILL, WAIT_TLB.
- Eligibility: eligible[t] = (state == RUN) & ~ext_stall[t] & ~(redirect_en & redirect_thread == t).
- Selection:
  - If id_ready and any thread is eligible, pick the first eligible thread searching cyclically from pointer+1.
  - On the next edge: issue_valid = 1, issue_thread = the winner, issue_pc = pc[winner]; winner goes to INFLIGHT; pointer = winner.
  - Otherwise issue_valid = 0 next edge, and issue_thread/issue_pc hold their values.
- Lookup result:
  - Valid only in a cycle with issue_valid = 1, and refers to issue_thread. Lookup latency is 0 relative to the issue registers.
  - Priority: itlb_miss > icache_miss > hit.
  - hit: pc += WORD_BYTES modulo 2^VADDR_W; thread goes to RUN.
  - icache_miss: pc unchanged; thread goes to WAIT_FILL.
  - itlb_miss: pc unchanged; thread goes to WAIT_TLB.
  - None asserted: treated as icache_miss.
  - The thread can therefore be reselected at the earliest 2 cycles after its previous issue.
- fill_valid: moves fill_thread from WAIT_FILL to RUN. It is ignored in any other state.
- WAIT_TLB is left only by a redirect (the exception handler refills the TLB, then redirects).
- Redirect:
  - pc[redirect_thread] = redirect_pc; the thread goes to RUN from any state.
  - If the redirected thread is INFLIGHT in that cycle, its lookup result is discarded.
  - Redirect beats fill and lookup results for the same thread in the same cycle.
  - Redirect never affects other threads.
- Simultaneous events on different threads (fill, lookup, redirect) all take effect in the same cycle.
- thread_waiting is registered from next state.
- id_ready low: the current in-flight result is still consumed, but no new issue is made.
- N_THREADS = 1: the pointer is constant. Issue is every other cycle at best.

Test Plan:
- Reset, N=4, all hits, id_ready=1 -> issues (t0,0x1000),(t1,0x1000),(t2,0x1000),(t3,0x1000),(t0,0x1004); then (t1,0x1004),(t2,0x1004),(t3,0x1004),(t0,0x1008).
- icache_miss on t1's first issue -> t1 is skipped and thread_waiting=4'b0010. fill_valid for t1 five cycles later -> bit clears; t1 reissues at 0x1000 in RR order.
- itlb_miss on t2; fill_valid for t2 -> t2 stays in WAIT_TLB. redirect t2 to 0x2000 -> next t2 issue has pc 0x2000.
- Redirect t0 to 0x3000 in the same cycle t0 is INFLIGHT with lookup_hit -> hit discarded; next t0 issue has pc 0x3000, not 0x1004.
- ext_stall=4'b1011 -> only t2 issues, every other cycle. id_ready=0 for 3 cycles -> issue_valid=0 for 3 cycles and PCs unchanged.
- pc = 2^VADDR_W-4 with a hit -> pc wraps to 0. Assert rst mid-miss -> all threads in RUN at RESET_PC, and the first issue is t0.
